// File: rtl/display_scan_8digit.sv
// display_scan_8digit: time-multiplexed 8-digit seven-segment scanner with frame-synchronous value update
module display_scan_8digit #(
   parameter int TICKS_PER_DIGIT = 100000,
   parameter int BLANK_TICKS     = 1000
) (
   input  logic        CLK100MHZ,
   input  logic        RST,
   input  logic [31:0] value,
   input  logic        load,
   input  logic [7:0]  dp_mask,
   input  logic [7:0]  digit_en,
   input  logic        blank_lz,
   output logic [7:0]  AN,
   output logic        CA,
   output logic        CB,
   output logic        CC,
   output logic        CD,
   output logic        CE,
   output logic        CF,
   output logic        CG,
   output logic        DP,
   output logic        frame_done
);
   localparam int CW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [31:0]   stage_q, stage_d, disp_q, disp_d;
   logic          pend_q, pend_d;
   logic [7:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d, fd_q, fd_d;
   logic          slot_end, frame_end, lit;
   logic [7:0]    hi_zero;
   logic [3:0]    nib;
   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: glyph = 7'b0000001;
         4'h1: glyph = 7'b1001111;
         4'h2: glyph = 7'b0010010;
         4'h3: glyph = 7'b0000110;
         4'h4: glyph = 7'b1001100;
         4'h5: glyph = 7'b0100100;
         4'h6: glyph = 7'b0100000;
         4'h7: glyph = 7'b0001111;
         4'h8: glyph = 7'b0000000;
         4'h9: glyph = 7'b0000100;
         4'hA: glyph = 7'b0001000;
         4'hB: glyph = 7'b1100000;
         4'hC: glyph = 7'b0110001;
         4'hD: glyph = 7'b1000010;
         4'hE: glyph = 7'b0110000;
         default: glyph = 7'b0111000;
      endcase
   endfunction
   // hi_zero[k]: display nibbles k..7 are all zero (leading-zero candidate)
   for (genvar g = 0; g < 8; g++) begin : g_hz
      assign hi_zero[g] = disp_q[31:4*g] == '0;
   end
   // scan timing, frame-synchronous display update, and next output values
   always_comb begin
      slot_end  = cnt_q == CW'(TICKS_PER_DIGIT - 1);
      frame_end = slot_end && idx_q == 3'd7;
      cnt_d     = slot_end ? '0 : cnt_q + CW'(1);
      idx_d     = slot_end ? idx_q + 3'd1 : idx_q;
      stage_d   = load ? value : stage_q;
      disp_d    = !frame_end ? disp_q : load ? value : pend_q ? stage_q : disp_q;
      pend_d    = !frame_end && (load || pend_q);
      nib       = disp_q[{idx_q, 2'b00} +: 4];
      lit       = digit_en[idx_q] && !(blank_lz && idx_q != 3'd0 && hi_zero[idx_q])
                  && int'(cnt_q) >= BLANK_TICKS;
      an_d      = lit ? ~(8'd1 << idx_q) : 8'hFF;
      seg_d     = lit ? glyph(nib) : 7'h7F;
      dp_d      = lit ? ~dp_mask[idx_q] : 1'b1;
      fd_d      = frame_end;
   end
   // state and registered outputs; reset blanks the display and restarts at digit 0
   always_ff @(posedge CLK100MHZ) begin
      if (RST) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         stage_q <= '0;
         disp_q  <= '0;
         pend_q  <= 1'b0;
         an_q    <= 8'hFF;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
         fd_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         stage_q <= stage_d;
         disp_q  <= disp_d;
         pend_q  <= pend_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         fd_q    <= fd_d;
      end
   end
   assign AN         = an_q;
   assign {CA, CB, CC, CD, CE, CF, CG} = seg_q;
   assign DP         = dp_q;
   assign frame_done = fd_q;
endmodule

// File: tb/tb_display_scan_8digit.sv
// tb_display_scan_8digit: randomized and directed checks of the scanner against a cycle-count reference model
module tb_display_scan_8digit;
   localparam int T = 4;
   localparam int B = 1;
   localparam int F = 8 * T;
   logic        clk = 1'b0;
   logic        rst, load, blank_lz;
   logic [31:0] value;
   logic [7:0]  dp_mask, digit_en, an;
   logic        ca, cb, cc, cd, ce, cf, cg, dp, fd;
   int          n_tests = 0, n_fail = 0;
   int          t;
   logic [31:0] m_disp, m_stage;
   logic        m_pend;
   logic [7:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dp, e_fd;

   display_scan_8digit #(.TICKS_PER_DIGIT(T), .BLANK_TICKS(B)) dut (
      .CLK100MHZ(clk), .RST(rst), .value(value), .load(load), .dp_mask(dp_mask),
      .digit_en(digit_en), .blank_lz(blank_lz), .AN(an), .CA(ca), .CB(cb), .CC(cc),
      .CD(cd), .CE(ce), .CF(cf), .CG(cg), .DP(dp), .frame_done(fd)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] ref_glyph(input logic [3:0] n);
      case (n)
         4'h0: return 7'b0000001;
         4'h1: return 7'b1001111;
         4'h2: return 7'b0010010;
         4'h3: return 7'b0000110;
         4'h4: return 7'b1001100;
         4'h5: return 7'b0100100;
         4'h6: return 7'b0100000;
         4'h7: return 7'b0001111;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0000100;
         4'hA: return 7'b0001000;
         4'hB: return 7'b1100000;
         4'hC: return 7'b0110001;
         4'hD: return 7'b1000010;
         4'hE: return 7'b0110000;
         default: return 7'b0111000;
      endcase
   endfunction

   function automatic int digit_of(input int tt);
      return (tt / T) % 8;
   endfunction

   function automatic logic lit_f(input int tt, input logic [31:0] d, input logic [7:0] en, input logic blz);
      int k = digit_of(tt);
      return en[k] && !(blz && k > 0 && (d >> (4 * k)) == 0) && (tt % T) >= B;
   endfunction

   // reference: t counts cycles since reset; outputs follow state one cycle later
   always @(posedge clk) begin
      if (rst) begin
         t       <= 0;
         m_disp  <= '0;
         m_stage <= '0;
         m_pend  <= 1'b0;
         e_an    <= 8'hFF;
         e_seg   <= 7'h7F;
         e_dp    <= 1'b1;
         e_fd    <= 1'b0;
      end else begin
         e_an  <= lit_f(t, m_disp, digit_en, blank_lz) ? 8'hFF ^ (8'd1 << digit_of(t)) : 8'hFF;
         e_seg <= lit_f(t, m_disp, digit_en, blank_lz) ? ref_glyph(4'((m_disp >> (4 * digit_of(t))) & 32'hF)) : 7'h7F;
         e_dp  <= lit_f(t, m_disp, digit_en, blank_lz) ? !dp_mask[digit_of(t)] : 1'b1;
         e_fd  <= (t % F) == F - 1;
         if ((t % F) == F - 1) begin
            m_disp <= load ? value : (m_pend ? m_stage : m_disp);
            m_pend <= 1'b0;
         end else if (load) m_pend <= 1'b1;
         if (load) m_stage <= value;
         t <= t + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at t=%0d: got %h expected %h", tag, t, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      chk("AN", an, e_an);
      chk("SEG", {ca, cb, cc, cd, ce, cf, cg}, e_seg);
      chk("DP", dp, e_dp);
      chk("FD", fd, e_fd);
   endtask

   task automatic wait_t(input int m);
      for (int i = 0; i < 2 * F && (t % F) != m; i++) step();
      chk("sync", t % F, m);
   endtask

   task automatic wait_an(input logic [7:0] a);
      for (int i = 0; i < 2 * F && e_an != a; i++) step();
      chk("wait_an", an, a);
   endtask

   task automatic pulse_load(input logic [31:0] v);
      load  = 1'b1;
      value = v;
      step();
      load  = 1'b0;
      value = $urandom;
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; blank_lz = 1'b0; value = '0;
      dp_mask = 8'h00; digit_en = 8'hFF;
      repeat (3) step();
      chk("rst_an", an, 8'hFF);
      chk("rst_seg", {ca, cb, cc, cd, ce, cf, cg}, 7'h7F);
      chk("rst_fd", fd, 1'b0);
      rst = 1'b0;
      step();
      chk("post_rst_an", an, 8'hFF);
      repeat (70) step();
      // value changes without load stay invisible
      wait_t(10);
      value = 32'hFFFF_FFFF;
      repeat (4) step();
      pulse_load(32'h0000_00A1);
      wait_t(0);
      wait_an(8'hFE);
      chk("a1_d0", {ca, cb, cc, cd, ce, cf, cg}, 7'b1001111);
      wait_an(8'hFD);
      chk("a1_d1", {ca, cb, cc, cd, ce, cf, cg}, 7'b0001000);
      blank_lz = 1'b1;
      repeat (40) step();
      pulse_load(32'h0);
      repeat (70) step();
      blank_lz = 1'b0;
      wait_t(5);
      pulse_load(32'h1111_1111);
      step();
      pulse_load(32'h8888_8888);
      wait_t(0);
      wait_an(8'hFB);
      chk("eight_d2", {ca, cb, cc, cd, ce, cf, cg}, 7'b0000000);
      wait_t(F - 1);
      pulse_load(32'h2345_6789);
      wait_an(8'hFE);
      chk("bnd_d0", {ca, cb, cc, cd, ce, cf, cg}, 7'b0000100);
      wait_t(5 * T + 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_an", an, 8'hFF);
      chk("mid_rst_fd", fd, 1'b0);
      repeat (40) step();
      dp_mask = 8'h04; digit_en = 8'hFE;
      pulse_load(32'h7654_3210);
      repeat (80) step();
      wait_an(8'hFB);
      chk("dp_d2", dp, 1'b0);
      for (int i = 0; i < 1200; i++) begin
         rst  = $urandom_range(0, 199) == 0;
         load = $urandom_range(0, 7) == 0;
         value = $urandom >> (4 * $urandom_range(0, 8));
         if ($urandom_range(0, 15) == 0) begin
            blank_lz = 1'($urandom);
            digit_en = 8'($urandom) | 8'($urandom);
            dp_mask  = 8'($urandom);
         end
         step();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/display_scan_8digit.md
DISPLAY_SCAN_8DIGIT -- requirements
Module: display_scan_8digit

Interface
REQ-001 Parameter TICKS_PER_DIGIT, default 100000, clock cycles per digit slot (1 ms at 100 MHz); legal range >= 2.
REQ-002 Parameter BLANK_TICKS, default 1000, cycles at start of each slot with all anodes off (anti-ghosting); legal range 0 to TICKS_PER_DIGIT-1.
REQ-003 CLK100MHZ  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 value  input  32  eight hex nibbles; value[4k+3:4k] is digit k, k=0 rightmost.
REQ-006 load  input  1  single-cycle strobe; stages value for display.
REQ-007 dp_mask  input  8  bit k high lights decimal point of digit k.
REQ-008 digit_en  input  8  bit k low forces digit k dark.
REQ-009 blank_lz  input  1  high enables leading-zero suppression.
REQ-010 AN  output  8  anode selects, active-low, at most one low per cycle.
REQ-011 CA,CB,CC,CD,CE,CF,CG  output  1 each  segments a-g, active-low.
REQ-012 DP  output  1  decimal point, active-low.
REQ-013 frame_done  output  1  one-cycle pulse when digit 7 slot ends.

Function
REQ-014 Tick counter SHALL count 0..TICKS_PER_DIGIT-1 then wrap to 0; wrap cycle is the slot boundary.
REQ-015 Digit index (3 bits) SHALL increment by 1 at each slot boundary, 7 wraps to 0.
REQ-016 frame_done SHALL be high for exactly the one cycle after the boundary where index goes 7->0.
REQ-017 load high SHALL write value into a staging register and set a pending flag; multiple loads before a frame boundary: last one wins.
REQ-018 At the 7->0 boundary, display register SHALL take staging if pending is set, then clear pending.
REQ-019 load asserted on the 7->0 boundary cycle SHALL be displayed from the new frame (bypass staging); pending ends cleared.
REQ-020 Display register SHALL be the only source for segment data; value changes without load SHALL have no visible effect.
REQ-021 Decoder SHALL map nibble 0-F to hex glyphs 0-9,A,b,C,d,E,F; {CA..CG}: 0=0000001, 1=1001111, 8=0000000, A=0001000, F=0111000.
REQ-022 Digit k SHALL be leading-zero blanked when blank_lz=1, k>0, and display nibbles k..7 are all zero; digit 0 never LZ-blanked.
REQ-023 Digit k is dark when digit_en[k]=0 or LZ-blanked; dark digit SHALL drive AN=8'hFF for whole slot.
REQ-024 For tick counter < BLANK_TICKS, AN SHALL be 8'hFF; otherwise AN = ~(1<<index) for lit digit.
REQ-025 Segments and DP SHALL be 1 (off) whenever AN=8'hFF.
REQ-026 DP SHALL be ~dp_mask[index] while digit lit; dp_mask, digit_en, blank_lz sampled live each cycle.
REQ-027 All outputs SHALL be registered; outputs reflect counter/index state with exactly 1 cycle latency.

Reset
REQ-028 RST=1 SHALL set counter=0, index=0, staging=0, display=0, pending=0 at the next edge.
REQ-029 During and one cycle after reset: AN=8'hFF, CA..CG=1, DP=1, frame_done=0.
REQ-030 RST SHALL override load in the same cycle; mid-frame reset restarts scan at digit 0, tick 0.
REQ-031 First lit digit after reset release: digit 0, in slot starting at tick BLANK_TICKS.

Verification (TICKS_PER_DIGIT=4, BLANK_TICKS=1)
REQ-032 Reset then idle, blank_lz=0, digit_en=FF -> AN cycles FE,FD,...,7F, each low 3 of 4 cycles, FF 1 cycle; segments 0000001; frame_done every 32 cycles.
REQ-033 load value=32'h0000_00A1 mid-frame -> no change until next frame; then digit0 shows 1001111, digit1 0001000.
REQ-034 Same value, blank_lz=1 -> digits 2..7 hold AN=FF all slot; digits 0,1 lit; value=0 -> only digit 0 lit showing 0.
REQ-035 Two loads (32'h1111_1111 then 32'h8888_8888) in one frame -> next frame all digits 0000000; load on 7->0 boundary cycle displayed in that frame.
REQ-036 RST pulse during digit 5 slot -> AN=FF next cycle, scan resumes digit 0, display register 0, frame_done not pulsed.
REQ-037 dp_mask=8'h04, digit_en=8'hFE -> DP=0 only in digit 2 lit cycles; digit 0 slot AN=FF.
